// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front end:
//   - fetch_state_e : fetch FSM state encoding
//   - INSTR_BYTES   : bytes per instruction word (PC increment)
//   - ptr_width()   : prefetch queue pointer width for a given depth
//   - count_width() : prefetch queue occupancy counter width for a given depth
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that "full" (count == depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular FIFO of {pc, instruction} entries used as the prefetch queue.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_push, i_push_pc,
//   i_push_instr        : write one entry at the tail (ignored when full)
//   i_pop               : retire the head entry (ignored when empty)
//   i_flush             : empty the queue; wins over push and pop
//   o_head_pc,
//   o_head_instr        : head entry, combinational from storage
//   o_count             : number of valid entries
//   o_full, o_empty     : occupancy flags
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int AW    = 32,
    parameter  int IW    = 32,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [AW-1:0]    i_push_pc,
    input  logic [IW-1:0]    i_push_instr,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [AW-1:0]    o_head_pc,
    output logic [IW-1:0]    o_head_instr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [AW-1:0]    r_pc_mem    [DEPTH];
    logic [IW-1:0]    r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !i_flush && !o_full;
    assign w_do_pop  = i_pop  && !i_flush && !o_empty;

    // Storage is not reset; consumers only look at it while count != 0.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_pc_mem[r_tail]    <= i_push_pc;
            r_instr_mem[r_tail] <= i_push_instr;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_tail <= r_tail + PTR_W'(1);
            if (w_do_pop)  r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_head_pc    = r_pc_mem[r_head];
    assign o_head_instr = r_instr_mem[r_head];
    assign o_count      = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
// Instruction fetch front end: runs ahead of decode, fetching sequential words
// from the blocking icache port into a prefetch queue; a branch/jump redirect
// flushes the queue and drops any stale in-flight response.
//   clock, reset          : clock, asynchronous active-high reset
//   branch_or_jump_signal : one-cycle redirect strobe
//   branch_jump_addres    : redirect target (bits [1:0] ignored)
//   imem_read/imem_address/imem_busywait/imem_instruction : icache port
//   dec_valid/dec_ready   : head-of-queue handshake towards decode
//   dec_pc/dec_pc_plus4/dec_instruction : head entry (0 while queue empty)
//   o_dbg_state           : current fetch FSM state (fetch_state_e)
//
// Handshakes: a cache request completes on the rising edge where
// imem_read=1 and imem_busywait=0; imem_address is held while busywait=1.
// Decode takes the head on the rising edge where dec_valid=1 and dec_ready=1.
// -----------------------------------------------------------------------------
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   branch_or_jump_signal,
    input  logic [ADDR_WIDTH-1:0]  branch_jump_addres,
    output logic                   imem_read,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic                   imem_busywait,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [ADDR_WIDTH-1:0]  dec_pc,
    output logic [ADDR_WIDTH-1:0]  dec_pc_plus4,
    output logic [INSTR_WIDTH-1:0] dec_instruction,
    output logic [1:0]             o_dbg_state
);

    localparam int                    CNT_W    = count_width(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_BYTES);

    fetch_state_e            r_state;
    fetch_state_e            w_next_state;
    logic [ADDR_WIDTH-1:0]   r_fetch_pc;
    logic [ADDR_WIDTH-1:0]   r_stale_addr;
    logic [ADDR_WIDTH-1:0]   w_target;
    logic                    w_complete;
    logic                    w_push;
    logic                    w_pop;
    logic [CNT_W-1:0]        w_count;
    logic [CNT_W-1:0]        w_count_next;
    logic                    w_q_full;
    logic                    w_q_empty;
    logic [ADDR_WIDTH-1:0]   w_head_pc;
    logic [INSTR_WIDTH-1:0]  w_head_instr;

    assign w_target   = {branch_jump_addres[ADDR_WIDTH-1:2], 2'b00};
    assign imem_read  = (r_state == ST_FETCH) || (r_state == ST_DISCARD);
    // In DISCARD the old request must stay on the bus until the cache finishes it.
    assign imem_address = (r_state == ST_DISCARD) ? r_stale_addr : r_fetch_pc;
    assign w_complete = imem_read && !imem_busywait;

    // A redirect suppresses both push and pop on its edge.
    assign w_push = (r_state == ST_FETCH) && w_complete && !branch_or_jump_signal;
    assign w_pop  = dec_valid && dec_ready && !branch_or_jump_signal;
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = ST_FETCH;
            ST_FETCH: begin
                if (branch_or_jump_signal) begin
                    // A completing request is simply dropped; otherwise the
                    // outstanding request must be drained in DISCARD.
                    w_next_state = w_complete ? ST_FETCH : ST_DISCARD;
                end else if (w_complete && (w_count_next == FULL_CNT)) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (branch_or_jump_signal || !w_q_full) w_next_state = ST_FETCH;
            end
            ST_DISCARD: begin
                // Once the stale response is retired, fetch from fetch_pc,
                // which already holds the most recent target.
                if (w_complete) w_next_state = ST_FETCH;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            if (branch_or_jump_signal) begin
                r_fetch_pc <= w_target;
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            end
            if ((r_state == ST_FETCH) && branch_or_jump_signal && !w_complete) begin
                r_stale_addr <= r_fetch_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .AW    (ADDR_WIDTH),
        .IW    (INSTR_WIDTH)
    ) u_queue (
        .i_clk        (clock),
        .i_rst        (reset),
        .i_push       (w_push),
        .i_push_pc    (r_fetch_pc),
        .i_push_instr (imem_instruction),
        .i_pop        (w_pop),
        .i_flush      (branch_or_jump_signal),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_count      (w_count),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty)
    );

    // Data outputs are forced to 0 while empty so reset shows zeros and
    // stale storage never leaks to decode.
    assign dec_valid       = !w_q_empty;
    assign dec_pc          = dec_valid ? w_head_pc : '0;
    assign dec_pc_plus4    = dec_valid ? (w_head_pc + PC_STEP) : '0;
    assign dec_instruction = dec_valid ? w_head_instr : '0;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        branch_or_jump_signal;
  logic [31:0] branch_jump_addres;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_busywait;
  logic [31:0] imem_instruction;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [31:0] dec_instruction;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_base;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- cache model: word content derived from its address ----
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  assign imem_instruction = word_at(imem_address);

  // completions seen on the bus
  always @(posedge clock) begin
    if (!reset && imem_read && !imem_busywait) n_done <= n_done + 1;
  end

  fetch_queue_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h100)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .branch_or_jump_signal (branch_or_jump_signal),
    .branch_jump_addres    (branch_jump_addres),
    .imem_read             (imem_read),
    .imem_address          (imem_address),
    .imem_busywait         (imem_busywait),
    .imem_instruction      (imem_instruction),
    .dec_valid             (dec_valid),
    .dec_ready             (dec_ready),
    .dec_pc                (dec_pc),
    .dec_pc_plus4          (dec_pc_plus4),
    .dec_instruction       (dec_instruction),
    .o_dbg_state           (o_dbg_state)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    check({tag, "_valid"}, 32'(dec_valid), 32'd1);
    check({tag, "_pc"}, dec_pc, pc);
    check({tag, "_pc4"}, dec_pc_plus4, p4);
    check({tag, "_instr"}, dec_instruction, word_at(pc));
  endtask

  task automatic check_bus(input string tag, input logic rd, input logic [31:0] addr);
    check({tag, "_read"}, 32'(imem_read), 32'(rd));
    check({tag, "_addr"}, imem_address, addr);
  endtask

  task automatic check_state(input string tag, input fetch_state_e st);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(st));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    branch_or_jump_signal = 1'b0;
    branch_jump_addres = 32'h0;
    imem_busywait = 1'b0;
    dec_ready = 1'b1;
    step();
    step();

    // reset values
    check_state("rst", ST_IDLE);
    check_bus("rst", 1'b0, 32'h100);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_pc", dec_pc, 32'h0);
    check("rst_pc4", dec_pc_plus4, 32'h0);
    check("rst_instr", dec_instruction, 32'h0);

    // ---- reset fetch, streaming with zero-wait cache ----
    reset = 1'b0;
    step();
    check_state("a1", ST_FETCH);
    check_bus("a1", 1'b1, 32'h100);
    check("a1_valid", 32'(dec_valid), 32'd0);
    step();
    check_head("a2", 32'h100);
    check_bus("a2", 1'b1, 32'h104);
    step();
    check_head("a3", 32'h104);
    check_bus("a3", 1'b1, 32'h108);

    // ---- async reset during a miss ----
    imem_busywait = 1'b1;
    dec_ready = 1'b0;
    step();
    check_head("m1", 32'h104);
    check_bus("m1", 1'b1, 32'h108);
    step();
    check_bus("m2", 1'b1, 32'h108);
    #3;
    reset = 1'b1;
    #1;
    check("arst_read", 32'(imem_read), 32'd0);
    check("arst_valid", 32'(dec_valid), 32'd0);
    check_state("arst", ST_IDLE);
    check("arst_addr", imem_address, 32'h100);
    imem_busywait = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("arel_valid", 32'(dec_valid), 32'd0);

    // ---- fill under stall ----
    n_base = n_done;
    step();
    check_state("f1", ST_FETCH);
    check_bus("f1", 1'b1, 32'h100);
    step();
    step();
    step();
    check_bus("f4", 1'b1, 32'h10C);
    check_head("f4", 32'h100);
    step();
    check_state("f5", ST_HOLD);
    check_bus("f5", 1'b0, 32'h110);
    check_head("f5", 32'h100);
    step();
    check_state("f6", ST_HOLD);
    check("f6_done", 32'(n_done - n_base), 32'd4);
    check_head("f6", 32'h100);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    check_head("f7", 32'h104);
    check_state("f7", ST_HOLD);
    step();
    check_state("f8", ST_FETCH);
    check_bus("f8", 1'b1, 32'h110);
    check_head("f8", 32'h104);
    step();
    check_state("f9", ST_HOLD);
    check_bus("f9", 1'b0, 32'h114);
    check_head("f9", 32'h104);
    check("f9_done", 32'(n_done - n_base), 32'd5);

    // ---- redirect during a miss ----
    reset = 1'b1;
    dec_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    check_head("r2", 32'h100);
    step();
    check_head("r3", 32'h104);
    check_bus("r3", 1'b1, 32'h108);
    imem_busywait = 1'b1;
    step();
    check("r4_valid", 32'(dec_valid), 32'd0);
    check_bus("r4", 1'b1, 32'h108);
    branch_or_jump_signal = 1'b1;
    branch_jump_addres = 32'h203;
    step();
    branch_or_jump_signal = 1'b0;
    check_state("r5", ST_DISCARD);
    check_bus("r5", 1'b1, 32'h108);
    check("r5_valid", 32'(dec_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_valid", 32'(dec_valid), 32'd0);
      check_bus("rd", 1'b1, 32'h108);
    end
    imem_busywait = 1'b0;
    step();
    check_state("r9", ST_FETCH);
    check("r9_valid", 32'(dec_valid), 32'd0);
    check_bus("r9", 1'b1, 32'h200);
    step();
    check_head("r10", 32'h200);
    check_bus("r10", 1'b1, 32'h204);

    // ---- redirect on a completion edge, then address wrap ----
    branch_or_jump_signal = 1'b1;
    branch_jump_addres = 32'hFFFF_FFFE;
    step();
    branch_or_jump_signal = 1'b0;
    check_state("c1", ST_FETCH);
    check("c1_valid", 32'(dec_valid), 32'd0);
    check_bus("c1", 1'b1, 32'hFFFF_FFFC);
    step();
    check_head("w1", 32'hFFFF_FFFC);
    check_bus("w1", 1'b1, 32'h0);
    step();
    check_head("w2", 32'h0);
    check_bus("w2", 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
